// File: rtl/photon_input_conditioner.sv
// Board-side input conditioning for the photon beacon: synchronizes and debounces the
// slide switches and the active-low center button, producing stable levels, edge pulses and a long-press hold.
module photon_input_conditioner #(
    parameter int N_SW        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 2_000_000,
    parameter int HOLD_CYCLES = 400_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw_raw,
    input  logic            btn_raw_n,
    output logic [N_SW-1:0] sw_stable,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            btn_pressed,
    output logic            btn_press_pulse,
    output logic            btn_hold,
    output logic            btn_hold_pulse,
    output logic            changed_any
);

    localparam int NCH    = N_SW + 1;
    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    // The button channel idles high (released) so reset never looks like a press.
    localparam logic [NCH-1:0]    SYNC_IDLE = {1'b1, {N_SW{1'b0}}};

    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
    logic [NCH-1:0]                  level_in;

    logic [NCH-1:0][DB_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]           stable_q, stable_d;
    logic [NCH-1:0]           rise_q, rise_d;
    logic [N_SW-1:0]          fall_q, fall_d;
    logic                     changed_q, changed_d;

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              hold_q, hold_d;
    logic              hold_pulse_q, hold_pulse_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{SYNC_IDLE}};
        end else begin
            sync_q[0] <= {btn_raw_n, sw_raw};
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Button is inverted here so every channel is active-high from this point on.
    assign level_in = {~sync_q[SYNC_STAGES-1][N_SW], sync_q[SYNC_STAGES-1][N_SW-1:0]};

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int c = 0; c < NCH; c++) begin
            if (level_in[c] == stable_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] == DB_LAST) begin
                stable_d[c] = level_in[c];
                cnt_d[c]    = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + DB_ONE;
            end
        end
    end

    assign rise_d    = stable_d & ~stable_q;
    assign fall_d    = ~stable_d[N_SW-1:0] & stable_q[N_SW-1:0];
    assign changed_d = (|rise_d) | (|fall_d);

    // Counting is gated on the registered level so hold rises HOLD_CYCLES after
    // btn_pressed; clearing uses the next level so hold drops with btn_pressed.
    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        hold_d       = hold_q;
        hold_pulse_d = 1'b0;
        if (!stable_d[N_SW]) begin
            hold_cnt_d = '0;
            hold_d     = 1'b0;
        end else if (stable_q[N_SW] && (hold_cnt_q != HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
            if (hold_cnt_d == HOLD_MAX) begin
                hold_d       = 1'b1;
                hold_pulse_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            stable_q     <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            changed_q    <= 1'b0;
            hold_cnt_q   <= '0;
            hold_q       <= 1'b0;
            hold_pulse_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            changed_q    <= changed_d;
            hold_cnt_q   <= hold_cnt_d;
            hold_q       <= hold_d;
            hold_pulse_q <= hold_pulse_d;
        end
    end

    assign sw_stable       = stable_q[N_SW-1:0];
    assign sw_rise         = rise_q[N_SW-1:0];
    assign sw_fall         = fall_q;
    assign btn_pressed     = stable_q[N_SW];
    assign btn_press_pulse = rise_q[N_SW];
    assign btn_hold        = hold_q;
    assign btn_hold_pulse  = hold_pulse_q;
    assign changed_any     = changed_q;

endmodule
